// File: rtl/sys_bridge_pkg.sv
// sys_bridge_pkg: shared encodings for the data-memory bridge.
//   - req_type encodings (W/H/HU/B/BU/none)
//   - exception codes (AdEL, AdES, DBE)
//   - FSM state type
//   - helpers: legal access type check, load byte-select and extension
package sys_bridge_pkg;

    localparam logic [3:0] TYPE_W    = 4'b0000;
    localparam logic [3:0] TYPE_H    = 4'b0010;
    localparam logic [3:0] TYPE_HU   = 4'b0011;
    localparam logic [3:0] TYPE_B    = 4'b0100;
    localparam logic [3:0] TYPE_BU   = 4'b0101;
    localparam logic [3:0] TYPE_NONE = 4'b1111;

    localparam logic [4:0] EXC_NONE = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_DBE  = 5'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Only the five defined access types start a transfer; every other
    // encoding (including 1111) is treated as "no access this cycle".
    function automatic logic is_access_type(input logic [3:0] t);
        return (t == TYPE_W) || (t == TYPE_H) || (t == TYPE_HU) ||
               (t == TYPE_B) || (t == TYPE_BU);
    endfunction

    // Selects the addressed byte/half from a bus word and extends it.
    function automatic logic [31:0] load_ext(input logic [31:0] word,
                                             input logic [3:0]  t,
                                             input logic [1:0]  off);
        logic [31:0] shifted;
        logic [15:0] half;
        logic [7:0]  byte_v;
        shifted = word >> {off, 3'b000};
        half    = shifted[15:0];
        byte_v  = shifted[7:0];
        case (t)
            TYPE_H:  return {{16{half[15]}}, half};
            TYPE_HU: return {16'h0, half};
            TYPE_B:  return {{24{byte_v[7]}}, byte_v};
            TYPE_BU: return {24'h0, byte_v};
            default: return word;
        endcase
    endfunction

endpackage

// File: rtl/sys_bridge_decode.sv
// sys_bridge_decode: combinational address decode for the bridge.
//   i_addr/i_type/i_we/i_wd : MEM-stage request fields
//   o_sel  : one-hot target, lowest channel index wins on overlap
//   o_exc  : range, alignment, word-only or write-protect violation
//   o_be   : byte enables for the access
//   o_wd   : store data shifted onto its byte lanes
module sys_bridge_decode
    import sys_bridge_pkg::*;
#(
    parameter int                          NUM_DEV       = 7,
    parameter int                          ADDR_W        = 16,
    parameter logic [NUM_DEV*ADDR_W-1:0]   DEV_BASE      = '0,
    parameter logic [NUM_DEV*ADDR_W-1:0]   DEV_LIMIT     = '0,
    parameter logic [NUM_DEV-1:0]          DEV_WORD_ONLY = 7'b1111110,
    parameter int                          NUM_WP        = 2,
    parameter logic [NUM_WP*ADDR_W-1:0]    WP_ADDR       = '0
) (
    input  logic [31:0]        i_addr,
    input  logic [3:0]         i_type,
    input  logic               i_we,
    input  logic [31:0]        i_wd,
    output logic [NUM_DEV-1:0] o_sel,
    output logic               o_exc,
    output logic [3:0]         o_be,
    output logic [31:0]        o_wd
);

    logic [ADDR_W-1:0] w_addr_w;
    logic              w_high;
    logic              w_found;
    logic              w_wp;
    logic              w_misalign;
    logic              w_word_only;

    assign w_addr_w = {i_addr[ADDR_W-1:2], 2'b00};
    assign w_high   = |i_addr[31:ADDR_W];

    always_comb begin
        o_sel   = '0;
        w_found = 1'b0;
        for (int i = 0; i < NUM_DEV; i++) begin
            if (!w_found &&
                (w_addr_w >= DEV_BASE[i*ADDR_W +: ADDR_W]) &&
                (w_addr_w <= DEV_LIMIT[i*ADDR_W +: ADDR_W])) begin
                o_sel[i] = 1'b1;
                w_found  = 1'b1;
            end
        end
    end

    always_comb begin
        w_wp = 1'b0;
        for (int j = 0; j < NUM_WP; j++) begin
            if (i_we && (w_addr_w == WP_ADDR[j*ADDR_W +: ADDR_W])) begin
                w_wp = 1'b1;
            end
        end
    end

    assign w_misalign  = ((i_type == TYPE_W) && (i_addr[1:0] != 2'b00)) ||
                         (((i_type == TYPE_H) || (i_type == TYPE_HU)) && i_addr[0]);
    assign w_word_only = (|(o_sel & DEV_WORD_ONLY)) && (i_type != TYPE_W);
    assign o_exc       = w_high || !w_found || w_misalign || w_word_only || w_wp;

    always_comb begin
        o_be = 4'b0000;
        o_wd = 32'h0;
        case (i_type)
            TYPE_W: begin
                o_be = 4'b1111;
                o_wd = i_wd;
            end
            TYPE_H, TYPE_HU: begin
                o_be = i_addr[1] ? 4'b1100 : 4'b0011;
                o_wd = {16'h0, i_wd[15:0]} << {i_addr[1], 4'b0000};
            end
            TYPE_B, TYPE_BU: begin
                o_be = 4'b0001 << i_addr[1:0];
                o_wd = {24'h0, i_wd[7:0]} << {i_addr[1:0], 3'b000};
            end
            default: begin
                o_be = 4'b0000;
                o_wd = 32'h0;
            end
        endcase
    end

endmodule

// File: rtl/sys_bridge.sv
// sys_bridge: MEM-stage to memory/peripheral bridge with req/ack handshake.
//   clk, reset_n          : clock, asynchronous active-low reset
//   req_*                 : MEM-stage access request, flush aborts/suppresses
//   stall                 : hold pipeline while an access is outstanding
//   rd_data, rd_valid     : extended load data and one-cycle completion
//   exc_occur, exc_code   : exception pulse and code (AdEL/AdES/DBE)
//   Pr*                   : registered bus side, PrRD/PrAck per channel
//   dbg_state             : current FSM state for observation
//
// Handshake: an access is offered on req_valid; the bridge accepts it in
// IDLE in the same cycle (stall=1) and completes it with a single rd_valid
// pulse, or ends it with exc_occur. On the bus, PrReq stays high with all
// Pr* fields stable until PrAck of the selected channel is seen.
module sys_bridge
    import sys_bridge_pkg::*;
#(
    parameter int                          NUM_DEV       = 7,
    parameter int                          ADDR_W        = 16,
    parameter logic [NUM_DEV*ADDR_W-1:0]   DEV_BASE      = '0,
    parameter logic [NUM_DEV*ADDR_W-1:0]   DEV_LIMIT     = '0,
    parameter logic [NUM_DEV-1:0]          DEV_WORD_ONLY = 7'b1111110,
    parameter int                          NUM_WP        = 2,
    parameter logic [NUM_WP*ADDR_W-1:0]    WP_ADDR       = '0,
    parameter int                          TIMEOUT       = 15
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req_valid,
    input  logic                  req_we,
    input  logic [3:0]            req_type,
    input  logic [31:0]           req_addr,
    input  logic [31:0]           req_wd,
    input  logic                  flush,
    output logic                  stall,
    output logic [31:0]           rd_data,
    output logic                  rd_valid,
    output logic                  exc_occur,
    output logic [4:0]            exc_code,
    output logic [ADDR_W-1:0]     PrAddr,
    output logic [31:0]           PrWD,
    output logic [3:0]            PrBE,
    output logic                  PrWE,
    output logic                  PrReq,
    output logic [NUM_DEV-1:0]    PrSel,
    input  logic [NUM_DEV*32-1:0] PrRD,
    input  logic [NUM_DEV-1:0]    PrAck,
    output logic [1:0]            dbg_state
);

    localparam int             CW      = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]  TO_LAST = CW'(TIMEOUT - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ADDR_W-1:0]  r_addr;
    logic [31:0]        r_wd;
    logic [3:0]         r_be;
    logic               r_we;
    logic [NUM_DEV-1:0] r_sel;
    logic [3:0]         r_type;
    logic [1:0]         r_off;
    logic [CW-1:0]      r_cnt;
    logic [31:0]        r_rd_data;

    logic [NUM_DEV-1:0] w_dec_sel;
    logic               w_dec_exc;
    logic [3:0]         w_dec_be;
    logic [31:0]        w_dec_wd;
    logic               w_req;
    logic               w_accept;
    logic               w_ack;
    logic               w_abort;
    logic               w_timeout;
    logic [31:0]        w_rd_word;

    sys_bridge_decode #(
        .NUM_DEV       (NUM_DEV),
        .ADDR_W        (ADDR_W),
        .DEV_BASE      (DEV_BASE),
        .DEV_LIMIT     (DEV_LIMIT),
        .DEV_WORD_ONLY (DEV_WORD_ONLY),
        .NUM_WP        (NUM_WP),
        .WP_ADDR       (WP_ADDR)
    ) u_decode (
        .i_addr (req_addr),
        .i_type (req_type),
        .i_we   (req_we),
        .i_wd   (req_wd),
        .o_sel  (w_dec_sel),
        .o_exc  (w_dec_exc),
        .o_be   (w_dec_be),
        .o_wd   (w_dec_wd)
    );

    assign w_req     = req_valid && is_access_type(req_type) && !flush;
    assign w_accept  = (r_state == ST_IDLE) && w_req && !w_dec_exc;
    // Acks from channels other than the selected one are masked off here.
    assign w_ack     = |(PrAck & r_sel);
    // A write has already been committed to the device, so flush only aborts reads.
    assign w_abort   = flush && !r_we;
    assign w_timeout = !w_ack && (r_cnt == TO_LAST);

    always_comb begin
        w_rd_word = 32'h0;
        for (int i = 0; i < NUM_DEV; i++) begin
            if (r_sel[i]) begin
                w_rd_word = w_rd_word | PrRD[i*32 +: 32];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        stall       = 1'b0;
        rd_valid    = 1'b0;
        exc_occur   = 1'b0;
        exc_code    = EXC_NONE;
        PrReq       = 1'b0;
        PrSel       = '0;
        PrAddr      = '0;
        PrWD        = 32'h0;
        PrBE        = 4'b0000;
        PrWE        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_req) begin
                    if (w_dec_exc) begin
                        exc_occur = 1'b1;
                        exc_code  = req_we ? EXC_ADES : EXC_ADEL;
                    end else begin
                        stall       = 1'b1;
                        w_state_nxt = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                stall  = 1'b1;
                PrReq  = 1'b1;
                PrSel  = r_sel;
                PrAddr = r_addr;
                PrWD   = r_wd;
                PrBE   = r_be;
                PrWE   = r_we;
                if (w_abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_ack) begin
                    w_state_nxt = ST_DONE;
                end else if (w_timeout) begin
                    exc_occur   = 1'b1;
                    exc_code    = EXC_DBE;
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_DONE: begin
                rd_valid    = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_addr    <= '0;
            r_wd      <= 32'h0;
            r_be      <= 4'b0000;
            r_we      <= 1'b0;
            r_sel     <= '0;
            r_type    <= TYPE_NONE;
            r_off     <= 2'b00;
            r_cnt     <= '0;
            r_rd_data <= 32'h0;
        end else if (w_accept) begin
            r_addr <= {req_addr[ADDR_W-1:2], 2'b00};
            r_wd   <= w_dec_wd;
            r_be   <= w_dec_be;
            r_we   <= req_we;
            r_sel  <= w_dec_sel;
            r_type <= req_type;
            r_off  <= req_addr[1:0];
            r_cnt  <= '0;
        end else if (r_state == ST_BUSY) begin
            r_cnt <= r_cnt + 1'b1;
            if (w_ack && !w_abort && !r_we) begin
                r_rd_data <= load_ext(w_rd_word, r_type, r_off);
            end
        end
    end

    assign rd_data   = r_rd_data;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_sys_bridge.sv
// tb_sys_bridge: directed-vector bench for sys_bridge.
// Map: ch0 memory 0x0000-0x2FFF, ch1..ch6 small word-only windows at
// 0x7F00 + 0x10*(i-1). Write-protected words 0x0100 and 0x7F08.
module tb_sys_bridge;
    import sys_bridge_pkg::*;

    localparam int NUM_DEV = 7;
    localparam int ADDR_W  = 16;
    localparam logic [NUM_DEV*ADDR_W-1:0] BASE  =
        {16'h7F50, 16'h7F40, 16'h7F30, 16'h7F20, 16'h7F10, 16'h7F00, 16'h0000};
    localparam logic [NUM_DEV*ADDR_W-1:0] LIMIT =
        {16'h7F5F, 16'h7F4F, 16'h7F3F, 16'h7F2F, 16'h7F1F, 16'h7F0F, 16'h2FFF};
    localparam logic [2*ADDR_W-1:0] WPA = {16'h7F08, 16'h0100};

    logic                  clk;
    logic                  reset_n;
    logic                  req_valid;
    logic                  req_we;
    logic [3:0]            req_type;
    logic [31:0]           req_addr;
    logic [31:0]           req_wd;
    logic                  flush;
    logic                  stall;
    logic [31:0]           rd_data;
    logic                  rd_valid;
    logic                  exc_occur;
    logic [4:0]            exc_code;
    logic [ADDR_W-1:0]     PrAddr;
    logic [31:0]           PrWD;
    logic [3:0]            PrBE;
    logic                  PrWE;
    logic                  PrReq;
    logic [NUM_DEV-1:0]    PrSel;
    logic [NUM_DEV*32-1:0] PrRD;
    logic [NUM_DEV-1:0]    PrAck;
    logic [1:0]            dbg_state;

    int n_checks = 0;
    int n_err    = 0;

    sys_bridge #(
        .NUM_DEV       (NUM_DEV),
        .ADDR_W        (ADDR_W),
        .DEV_BASE      (BASE),
        .DEV_LIMIT     (LIMIT),
        .DEV_WORD_ONLY (7'b1111110),
        .NUM_WP        (2),
        .WP_ADDR       (WPA),
        .TIMEOUT       (15)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_type  (req_type),
        .req_addr  (req_addr),
        .req_wd    (req_wd),
        .flush     (flush),
        .stall     (stall),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .exc_occur (exc_occur),
        .exc_code  (exc_code),
        .PrAddr    (PrAddr),
        .PrWD      (PrWD),
        .PrBE      (PrBE),
        .PrWE      (PrWE),
        .PrReq     (PrReq),
        .PrSel     (PrSel),
        .PrRD      (PrRD),
        .PrAck     (PrAck),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // driver tasks
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive_req(input logic we, input logic [3:0] t,
                             input logic [31:0] addr, input logic [31:0] wd);
        req_valid = 1'b1;
        req_we    = we;
        req_type  = t;
        req_addr  = addr;
        req_wd    = wd;
    endtask

    task automatic idle_req();
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_type  = TYPE_NONE;
        req_addr  = 32'h0;
        req_wd    = 32'h0;
    endtask

    // Memory load with ack in the first BUSY cycle; checks completion data.
    task automatic mem_load(input string tag, input logic [3:0] t, input logic [31:0] addr,
                            input logic [31:0] word, input logic [31:0] exp);
        drive_req(1'b0, t, addr, 32'h0);
        PrRD[31:0] = word;
        step();
        idle_req();
        PrAck = 7'b0000001;
        step();
        PrAck = 7'b0000000;
        #1;
        chk({tag, "_valid"}, {31'h0, rd_valid}, 32'h1);
        chk({tag, "_data"}, rd_data, exp);
        step();
    endtask

    int  n_busy;
    logic [4:0] code_seen;
    logic done;

    initial begin
        reset_n = 1'b0;
        flush   = 1'b0;
        PrRD    = '0;
        PrAck   = '0;
        idle_req();
        #3;
        chk("rst_stall", {31'h0, stall}, 32'h0);
        chk("rst_rd_valid", {31'h0, rd_valid}, 32'h0);
        chk("rst_exc", {31'h0, exc_occur}, 32'h0);
        chk("rst_prreq", {31'h0, PrReq}, 32'h0);
        chk("rst_prsel", {25'h0, PrSel}, 32'h0);
        chk("rst_rd_data", rd_data, 32'h0);
        chk("rst_state", {30'h0, dbg_state}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        step();

        // LW 0x1004, ack in first BUSY cycle
        drive_req(1'b0, TYPE_W, 32'h0000_1004, 32'h0);
        PrRD[31:0] = 32'hDEADBEEF;
        #1;
        chk("lw_stall_accept", {31'h0, stall}, 32'h1);
        chk("lw_prreq_idle", {31'h0, PrReq}, 32'h0);
        step();
        idle_req();
        PrAck = 7'b0000001;
        #1;
        chk("lw_stall_busy", {31'h0, stall}, 32'h1);
        chk("lw_prreq", {31'h0, PrReq}, 32'h1);
        chk("lw_prsel", {25'h0, PrSel}, 32'h1);
        chk("lw_prbe", {28'h0, PrBE}, 32'hF);
        chk("lw_praddr", {16'h0, PrAddr}, 32'h1004);
        chk("lw_prwe", {31'h0, PrWE}, 32'h0);
        step();
        PrAck = 7'b0000000;
        #1;
        chk("lw_rd_valid", {31'h0, rd_valid}, 32'h1);
        chk("lw_rd_data", rd_data, 32'hDEADBEEF);
        chk("lw_stall_done", {31'h0, stall}, 32'h0);
        step();
        chk("lw_rd_valid_pulse", {31'h0, rd_valid}, 32'h0);
        chk("lw_back_idle", {30'h0, dbg_state}, 32'h0);

        // SB 0x0003, wd=0xA5
        drive_req(1'b1, TYPE_B, 32'h0000_0003, 32'h0000_00A5);
        step();
        idle_req();
        #1;
        chk("sb_prbe", {28'h0, PrBE}, 32'h8);
        chk("sb_prwd", PrWD, 32'hA500_0000);
        chk("sb_prwe", {31'h0, PrWE}, 32'h1);
        chk("sb_praddr", {16'h0, PrAddr}, 32'h0000);
        // flush while a write is outstanding must not abort it
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("sb_flush_ignored", {30'h0, dbg_state}, 32'h1);
        PrAck = 7'b0000001;
        step();
        PrAck = 7'b0000000;
        chk("sb_done", {31'h0, rd_valid}, 32'h1);
        step();

        // SH 0x0006, wd=0x1234BEEF -> upper half lanes
        drive_req(1'b1, TYPE_H, 32'h0000_0006, 32'h1234_BEEF);
        step();
        idle_req();
        #1;
        chk("sh_prbe", {28'h0, PrBE}, 32'hC);
        chk("sh_prwd", PrWD, 32'hBEEF_0000);
        PrAck = 7'b0000001;
        step();
        PrAck = 7'b0000000;
        step();

        // LH 0x0001: misaligned -> AdEL, same cycle, no bus activity
        drive_req(1'b0, TYPE_H, 32'h0000_0001, 32'h0);
        #1;
        chk("lh_mis_exc", {31'h0, exc_occur}, 32'h1);
        chk("lh_mis_code", {27'h0, exc_code}, 32'h4);
        chk("lh_mis_stall", {31'h0, stall}, 32'h0);
        step();
        idle_req();
        chk("lh_mis_prreq", {31'h0, PrReq}, 32'h0);
        chk("lh_mis_state", {30'h0, dbg_state}, 32'h0);

        // SW to write-protected 0x0100 -> AdES
        drive_req(1'b1, TYPE_W, 32'h0000_0100, 32'h1111_2222);
        #1;
        chk("sw_wp_code", {27'h0, exc_code}, 32'h5);
        step();
        idle_req();
        chk("sw_wp_prwe", {31'h0, PrWE}, 32'h0);

        // LB on word-only channel 1 -> AdEL
        drive_req(1'b0, TYPE_B, 32'h0000_7F01, 32'h0);
        #1;
        chk("lb_wordonly_code", {27'h0, exc_code}, 32'h4);
        // unmapped and above-ADDR_W addresses
        req_type = TYPE_W;
        req_addr = 32'h0000_4000;
        #1;
        chk("lw_unmapped_code", {27'h0, exc_code}, 32'h4);
        req_addr = 32'h0001_1000;
        req_we   = 1'b1;
        #1;
        chk("sw_high_code", {27'h0, exc_code}, 32'h5);
        // flush suppresses the exception entirely
        flush = 1'b1;
        #1;
        chk("flush_suppress", {31'h0, exc_occur}, 32'h0);
        flush = 1'b0;
        step();
        idle_req();

        // LW to ch1 that never acks; other channels ack and must be ignored
        drive_req(1'b0, TYPE_W, 32'h0000_7F00, 32'h0);
        n_busy    = 0;
        code_seen = 5'd0;
        done      = 1'b0;
        for (int k = 1; k <= 40 && !done; k++) begin
            step();
            if (k == 1) begin
                idle_req();
                PrAck = 7'b1111101;
            end
            #1;
            if (exc_occur) begin
                n_busy    = k;
                code_seen = exc_code;
                done      = 1'b1;
            end
        end
        PrAck = 7'b0000000;
        chk("dbe_cycles", n_busy, 32'd15);
        chk("dbe_code", {27'h0, code_seen}, 32'h7);
        step();
        chk("dbe_back_idle", {30'h0, dbg_state}, 32'h0);
        chk("dbe_no_rd_valid", {31'h0, rd_valid}, 32'h0);

        // Read aborted by flush in BUSY
        drive_req(1'b0, TYPE_W, 32'h0000_1000, 32'h0);
        step();
        idle_req();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("abort_state", {30'h0, dbg_state}, 32'h0);
        chk("abort_no_rd_valid", {31'h0, rd_valid}, 32'h0);

        // Load extension cases
        mem_load("lb_sign", TYPE_B, 32'h0000_0002, 32'h0080_0000, 32'hFFFF_FF80);
        mem_load("lbu_zero", TYPE_BU, 32'h0000_0002, 32'h0080_0000, 32'h0000_0080);
        mem_load("lh_sign", TYPE_H, 32'h0000_0012, 32'h8001_1234, 32'hFFFF_8001);
        mem_load("lhu_zero", TYPE_HU, 32'h0000_0010, 32'h8001_9234, 32'h0000_9234);

        // Reset asserted mid-BUSY
        drive_req(1'b0, TYPE_W, 32'h0000_7F10, 32'h0);
        step();
        idle_req();
        chk("pre_rst_busy", {31'h0, PrReq}, 32'h1);
        reset_n = 1'b0;
        #1;
        chk("midrst_prreq", {31'h0, PrReq}, 32'h0);
        chk("midrst_stall", {31'h0, stall}, 32'h0);
        chk("midrst_state", {30'h0, dbg_state}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        step();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/sys_bridge.md
Name: sys_bridge

Overview:
- Parametrised successor of the single-cycle data-memory bridge between the CPU MEM stage and memory plus NUM_DEV peripherals.
- Decodes the address against a parameter table and raises AdEL/AdES on range, alignment, width or write-protect violations.
- Generates byte enables and write-data lanes, and sign/zero-extends load data internally.
- Adds a registered request/ack handshake with CPU stall and a timeout that reports a data bus error (DBE), so multi-cycle devices are supported.

Parameters:
- NUM_DEV, 7, number of targets; channel 0 is memory.
- ADDR_W, 16, width of PrAddr.
- DEV_BASE, {7 x 16'h0}, packed NUM_DEV*ADDR_W base addresses (inclusive).
- DEV_LIMIT, {7 x 16'h0}, packed NUM_DEV*ADDR_W limit addresses (inclusive).
- DEV_WORD_ONLY, 7'b1111110, bit i=1: channel i accepts only LW/SW.
- NUM_WP, 2, number of write-protected word addresses.
- WP_ADDR, {2 x 16'h0}, packed NUM_WP*ADDR_W write-protected addresses.
- TIMEOUT, 15, cycles in BUSY without ack before DBE; counter width is $clog2(TIMEOUT+1).

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  1  MEM-stage access request
- req_we  in  1  1 = store
- req_type  in  4  0000 W, 0010 H, 0011 HU, 0100 B, 0101 BU, 1111 none
- req_addr  in  32  byte address
- req_wd  in  32  store data
- flush  in  1  earlier-stage exception; suppresses or aborts the access
- stall  out  1  hold the pipeline
- rd_data  out  32  extended load data
- rd_valid  out  1  one-cycle load/store completion
- exc_occur  out  1  exception pulse
- exc_code  out  5  4 AdEL, 5 AdES, 7 DBE, else 0
- PrAddr  out  ADDR_W  word-aligned bus address
- PrWD  out  32  lane-shifted store data
- PrBE  out  4  byte enables
- PrWE  out  1  write strobe
- PrReq  out  1  bus request
- PrSel  out  NUM_DEV  one-hot target
- PrRD  in  NUM_DEV*32  per-channel read data
- PrAck  in  NUM_DEV  per-channel acknowledge

Behaviour:
- Reset: all outputs are 0 and the FSM is in IDLE.
- Decode (combinational, in IDLE): hit[i] = base_i <= addr[ADDR_W-1:2]<<2 <= limit_i. Lowest index wins on overlap.
- Exceptions, any of:
  - |addr[31:ADDR_W] set, or no hit;
  - W not aligned to 4;
  - H/HU not aligned to 2;
  - non-W type on a DEV_WORD_ONLY channel;
  - store to a WP_ADDR.
  - Code is AdES when req_we=1, else AdEL.
- FSM states IDLE, BUSY, DONE.
- IDLE:
  - If req_valid & type!=1111 & flush: no action.
  - If req_valid & type!=1111 & !flush with a decode exception: exc_occur=1 in the same cycle, no bus activity, stay in IDLE.
  - Otherwise: register addr, BE, WD, WE, sel and type; go to BUSY and assert stall.
- BUSY:
  - PrReq=1; PrSel, PrAddr, PrBE, PrWD and PrWE are held from registers.
  - If PrAck[sel]: latch PrRD[sel] and go to DONE.
  - Else, if the counter reaches TIMEOUT: exc_occur=1, exc_code=7, go to IDLE.
  - flush on a read: abort, return to IDLE, no rd_valid.
  - flush on a write: ignored, because the device has already been committed.
  - stall=1 throughout BUSY.
- DONE:
  - rd_valid=1 for one cycle, stall=0, return to IDLE.
  - rd_data is the extended, byte-selected word.
- Minimum latency is 2 cycles (accept, ack in the first BUSY cycle, DONE).
- Byte enables: W=1111; H={0011,1100} by addr[1]; B=one-hot by addr[1:0]. Store data is lane-shifted to match.
- Load extension: H/B sign-extend, HU/BU zero-extend.
- Ack on a non-selected channel is ignored.
- The timeout counter clears on entry to BUSY.
- Reset asserted mid-BUSY: immediate return to IDLE and all outputs 0.

Decomposition:
- Shared constants in macro.vh: req_type encodings, EXC_ADEL/EXC_ADES/EXC_DBE, FSM state encodings.
- One natural sub-module, bridge_decode: combinational hit/exception/BE/lane logic, reused in IDLE.

Test Plan:
- LW 0x0000_1004 with mem ack in the first BUSY cycle and PrRD[0]=0xDEADBEEF -> stall for 2 cycles, then rd_valid with rd_data=0xDEADBEEF, PrBE=1111.
- SB 0x0000_0003 with wd=0x000000A5 -> PrBE=1000, PrWD=0xA5000000, PrWE=1 during BUSY.
- LH 0x0000_0001 -> exc_occur in the same cycle, exc_code=4, PrReq never asserted.
- SW to WP_ADDR[0] -> exc_code=5, PrWE stays 0.
- LW to a device that never acks, TIMEOUT=15 -> exc_code=7 after 15 BUSY cycles, FSM back in IDLE.
- LB from 0x0000_0002 with PrRD[0]=0x00800000 -> rd_data=0xFFFFFF80; the same access with LBU -> 0x00000080.
